// File: rtl/subtractor_serial_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface subtractor_serial_if #(
  parameter int unsigned N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bi;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] d;
  logic         bo;
  logic         ov;

  modport master (
    output in_valid, a, b, bi, out_ready,
    input  in_ready, out_valid, d, bo, ov
  );

  modport slave (
    input  in_valid, a, b, bi, out_ready,
    output in_ready, out_valid, d, bo, ov
  );
endinterface

// File: rtl/subtractor_serial.sv
// Bit-serial subtractor d = a - b - bi: one full-subtractor cell per clock, LSB first,
// with valid/ready handshakes on operands and result.
module subtractor_serial #(
  parameter int unsigned N = 8
) (
  input logic               clk,
  input logic               rstn,
  subtractor_serial_if.slave bus
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  sa, sa_nxt;
  logic [N-1:0]  sb, sb_nxt;
  logic [N-1:0]  d_q, d_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          brw, brw_nxt;
  logic          a_msb, a_msb_nxt;
  logic          b_msb, b_msb_nxt;
  logic          in_ready_q, in_ready_nxt;
  logic          out_valid_q, out_valid_nxt;
  logic          bo_q, bo_nxt;
  logic          ov_q, ov_nxt;
  logic          x_c;

  // State, shift registers and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      sa          <= '0;
      sb          <= '0;
      d_q         <= '0;
      cnt         <= '0;
      brw         <= 1'b0;
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bo_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      state       <= state_nxt;
      sa          <= sa_nxt;
      sb          <= sb_nxt;
      d_q         <= d_nxt;
      cnt         <= cnt_nxt;
      brw         <= brw_nxt;
      a_msb       <= a_msb_nxt;
      b_msb       <= b_msb_nxt;
      in_ready_q  <= in_ready_nxt;
      out_valid_q <= out_valid_nxt;
      bo_q        <= bo_nxt;
      ov_q        <= ov_nxt;
    end
  end

  // Next-state, datapath and next-output logic
  always_comb begin
    state_nxt = state;
    sa_nxt    = sa;
    sb_nxt    = sb;
    d_nxt     = d_q;
    cnt_nxt   = cnt;
    brw_nxt   = brw;
    a_msb_nxt = a_msb;
    b_msb_nxt = b_msb;
    bo_nxt    = bo_q;
    ov_nxt    = ov_q;
    x_c       = sa[0] ^ sb[0] ^ brw;

    case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          sa_nxt    = bus.a;
          sb_nxt    = bus.b;
          brw_nxt   = bus.bi;
          a_msb_nxt = bus.a[N-1];
          b_msb_nxt = bus.b[N-1];
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        brw_nxt = (~sa[0] & sb[0]) | (~sa[0] & brw) | (sb[0] & brw);
        sa_nxt  = sa >> 1;
        sb_nxt  = sb >> 1;
        // Difference bit enters at the MSB so the LSB lands at bit 0 after N cycles
        d_nxt   = N'({x_c, d_q} >> 1);
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_nxt = DONE;
          bo_nxt    = brw_nxt;
          ov_nxt    = (a_msb != b_msb) && (x_c != a_msb);
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.d         = d_q;
  assign bus.bo        = bo_q;
  assign bus.ov        = ov_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Bench for subtractor_serial: directed N=8 vectors and corner sequences, then
// randomized back-to-back traffic on N=1 and N=16 against an arithmetic model.
module tb_subtractor_serial;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } res_t;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  subtractor_serial_if #(.N(8)) bus8 ();
  subtractor_serial #(.N(8)) u_dut8 (.clk(clk), .rstn(rstn), .bus(bus8.slave));

  // Random-traffic harnesses: index 0 is N=1, index 1 is N=16
  logic        rv[2];
  logic [15:0] ra[2];
  logic [15:0] rb[2];
  logic        rbi[2];
  logic        ro[2];
  logic        rin_ready[2];
  logic        rout_valid[2];
  logic [15:0] rd[2];
  logic        rbo[2];
  logic        rov[2];

  for (genvar k = 0; k < 2; k++) begin : g_rnd
    localparam int unsigned W = (k == 0) ? 1 : 16;
    subtractor_serial_if #(.N(W)) rif ();
    subtractor_serial #(.N(W)) u_dut (.clk(clk), .rstn(rstn), .bus(rif.slave));
    assign rif.in_valid  = rv[k];
    assign rif.a         = W'(ra[k]);
    assign rif.b         = W'(rb[k]);
    assign rif.bi        = rbi[k];
    assign rif.out_ready = ro[k];
    assign rin_ready[k]  = rif.in_ready;
    assign rout_valid[k] = rif.out_valid;
    assign rd[k]         = 16'(rif.d);
    assign rbo[k]        = rif.bo;
    assign rov[k]        = rif.ov;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands
  function automatic res_t ref_sub(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic bin);
    res_t r;
    int m, av, bv, full, sa, sb, sd;
    m    = 1 << w;
    av   = int'(a) & (m - 1);
    bv   = int'(b) & (m - 1);
    full = av - bv - int'(bin);
    r.d  = 16'(full & (m - 1));
    r.bo = (full < 0);
    sa   = (av >= m / 2) ? av - m : av;
    sb   = (bv >= m / 2) ? bv - m : bv;
    sd   = sa - sb - int'(bin);
    r.ov = (sd < -(m / 2)) || (sd > (m / 2 - 1));
    return r;
  endfunction

  // Present one operand set, then wait (bounded) for out_valid; lat = edges after accept
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int lat);
    @(negedge clk);
    bus8.a        = a;
    bus8.b        = b;
    bus8.bi       = bin;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.a        = ~a;
    bus8.b        = ~b;
    bus8.bi       = ~bin;
    lat = 0;
    while (!bus8.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t tbl[9];
  int   acc[2];
  int   got[2];
  res_t pend[2];
  bit   has_pend[2];

  initial begin
    int   lat;
    bit   seen;
    res_t e;

    rstn           = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.bi        = 1'b0;
    bus8.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0; ra[k] = '0; rb[k] = '0; rbi[k] = 1'b0; ro[k] = 1'b0;
      acc[k] = 0; got[k] = 0; has_pend[k] = 1'b0;
    end

    //           a      b      bi    d      bo    ov
    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[8] = '{8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_d", 32'(bus8.d), 32'd0);
    chk("rst_bo", 32'(bus8.bo), 32'd0);
    chk("rst_ov", 32'(bus8.ov), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus8.in_ready), 32'd1);

    // Directed table with out_ready held high throughout
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bi, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      chk($sformatf("vec%0d_d", i), 32'(bus8.d), 32'(tbl[i].d));
      chk($sformatf("vec%0d_bo", i), 32'(bus8.bo), 32'(tbl[i].bo));
      chk($sformatf("vec%0d_ov", i), 32'(bus8.ov), 32'(tbl[i].ov));
      @(negedge clk);
      chk($sformatf("vec%0d_valid_drop", i), 32'(bus8.out_valid), 32'd0);
      chk($sformatf("vec%0d_ready_back", i), 32'(bus8.in_ready), 32'd1);
      chk($sformatf("vec%0d_d_held", i), 32'(bus8.d), 32'(tbl[i].d));
    end

    // Consumer stall: result must stay put while out_ready is low
    bus8.out_ready = 1'b0;
    run_op(8'h10, 8'h10, 1'b1, lat);
    chk("stall_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stall%0d_out", i), {bus8.out_valid, bus8.bo, 22'd0, bus8.d},
          {1'b1, 1'b1, 22'd0, 8'hFF});
      @(negedge clk);
    end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 32'(bus8.out_valid), 32'd0);

    // Operands offered mid-SHIFT are ignored
    @(negedge clk);
    bus8.a = 8'h05; bus8.b = 8'h03; bus8.bi = 1'b0; bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    @(negedge clk);
    bus8.a = 8'hAA; bus8.b = 8'h11; bus8.bi = 1'b1; bus8.in_valid = 1'b1;
    chk("busy_in_ready", 32'(bus8.in_ready), 32'd0);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_result", {bus8.out_valid, bus8.bo, bus8.ov, 21'd0, bus8.d},
        {1'b1, 1'b0, 1'b0, 21'd0, 8'h02});
    @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | bus8.out_valid;
    end
    chk("busy_not_captured", 32'(seen), 32'd0);

    // Reset in the middle of SHIFT aborts the operation
    bus8.a = 8'h5A; bus8.b = 8'h0F; bus8.bi = 1'b1; bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("abort_d", 32'(bus8.d), 32'd0);
    chk("abort_in_ready", 32'(bus8.in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | bus8.out_valid;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run_op(8'h80, 8'h01, 1'b0, lat);
    chk("after_abort_latency", 32'(lat), 32'd8);
    chk("after_abort_result", {bus8.bo, bus8.ov, 22'd0, bus8.d}, {1'b0, 1'b1, 22'd0, 8'h7F});
    @(negedge clk);

    // Randomized back-to-back traffic on N=1 and N=16 with random out_ready
    for (int cyc = 0; cyc < 40000 && (got[0] < 1000 || got[1] < 1000); cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        rv[k]  = (acc[k] < 1000) && ($urandom_range(7) != 0);
        ra[k]  = 16'($urandom);
        rb[k]  = 16'($urandom);
        rbi[k] = 1'($urandom);
        ro[k]  = ($urandom_range(1) == 1);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (rout_valid[k] && ro[k]) begin
          e = has_pend[k] ? pend[k] : '{d: 16'hDEAD, bo: 1'b1, ov: 1'b1};
          chk($sformatf("rnd_n%0d_op%0d", (k == 0) ? 1 : 16, got[k]),
              {14'd0, rd[k], rbo[k], rov[k]}, {14'd0, e.d, e.bo, e.ov});
          has_pend[k] = 1'b0;
          got[k]++;
        end
        if (rv[k] && rin_ready[k]) begin
          pend[k]     = ref_sub((k == 0) ? 1 : 16, ra[k], rb[k], rbi[k]);
          has_pend[k] = 1'b1;
          acc[k]++;
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0;
      ro[k] = 1'b0;
      chk($sformatf("rnd_n%0d_count", (k == 0) ? 1 : 16), 32'(got[k]), 32'd1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
